// File: rtl/line_buf_wr.sv
// line_buf_wr: writes incoming video lines round-robin into four line RAMs for a 3x3 reader.
// Optional macro LBW_SHORT_PAD_EN zero-fills short lines up to image_width via the PAD state.
module line_buf_wr #(
   parameter int unsigned bit_depth    = 8,
   parameter logic [10:0] image_width  = 11'd1920,
   parameter logic [10:0] image_height = 11'd1080
) (
   input  logic                   clk,
   input  logic                   RESET,
   input  logic                   sof,
   input  logic                   de_in,
   input  logic [bit_depth*3-1:0] pix_in,
   output logic [10:0]            wr_addr,
   output logic [bit_depth*3-1:0] wr_data,
   output logic                   in0_wren,
   output logic                   in1_wren,
   output logic                   in2_wren,
   output logic                   in3_wren,
   output logic                   start_rd,
   output logic [10:0]            line_cnt,
   output logic                   err_short,
   output logic                   err_long
);

   localparam int unsigned PIX_W  = bit_depth * 3;
   localparam int unsigned AW     = 11;
   localparam int unsigned BANKS  = 4;
   localparam int unsigned BANK_W = 2;

   typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DONE} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]    wr_data_q, wr_data_d;
   logic [BANKS-1:0]    wren_q, wren_d;
   logic [AW-1:0]       line_cnt_q, line_cnt_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic [AW-1:0]       pix_cnt_q, pix_cnt_d;
   logic                start_rd_q, start_rd_d;
   logic                err_short_q, err_short_d;
   logic                err_long_q, err_long_d;
   logic                de_prev_q, de_prev_d;
   logic                drop_q, drop_d;
   logic                line_end;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q     <= IDLE;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wren_q      <= '0;
         line_cnt_q  <= '0;
         bank_q      <= '0;
         pix_cnt_q   <= '0;
         start_rd_q  <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         de_prev_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wren_q      <= wren_d;
         line_cnt_q  <= line_cnt_d;
         bank_q      <= bank_d;
         pix_cnt_q   <= pix_cnt_d;
         start_rd_q  <= start_rd_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         de_prev_q   <= de_prev_d;
         drop_q      <= drop_d;
      end
   end

   // Next-state: pixel acceptance, line termination, frame restart
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wren_d      = '0;
      line_cnt_d  = line_cnt_q;
      bank_d      = bank_q;
      pix_cnt_d   = pix_cnt_q;
      start_rd_d  = start_rd_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      de_prev_d   = de_in;
      drop_d      = drop_q & de_in;
      line_end    = 1'b0;

      unique case (state_q)
         IDLE: ;
         ACTIVE: begin
            // A full line ends one cycle after its last write; a short one on the de_in fall
            if (pix_cnt_q == image_width) begin
               line_end = 1'b1;
            end else if (!de_in && de_prev_q && (pix_cnt_q != '0)) begin
               err_short_d = 1'b1;
`ifdef LBW_SHORT_PAD_EN
               state_d = PAD;
`else
               line_end = 1'b1;
`endif
            end
            if (de_in) begin
               if (drop_q || (pix_cnt_q == image_width)) begin
                  err_long_d = 1'b1;
                  drop_d     = 1'b1;
               end else begin
                  wren_d[bank_q] = 1'b1;
                  wr_addr_d      = pix_cnt_q;
                  wr_data_d      = pix_in;
                  pix_cnt_d      = pix_cnt_q + AW'(1);
               end
            end
         end
`ifdef LBW_SHORT_PAD_EN
         PAD: begin
            if (de_in) begin
               err_long_d = 1'b1;
               drop_d     = 1'b1;
            end
            if (pix_cnt_q == image_width) begin
               line_end = 1'b1;
               state_d  = ACTIVE;
            end else begin
               wren_d[bank_q] = 1'b1;
               wr_addr_d      = pix_cnt_q;
               wr_data_d      = '0;
               pix_cnt_d      = pix_cnt_q + AW'(1);
            end
         end
`endif
         DONE: ;
         default: state_d = IDLE;
      endcase

      if (line_end) begin
         pix_cnt_d = '0;
         bank_d    = bank_q + BANK_W'(1);
         if (line_cnt_q != image_height) begin
            line_cnt_d = line_cnt_q + AW'(1);
         end
         if ((line_cnt_q + AW'(1)) == image_height) begin
            state_d = DONE;
         end
      end

      if (line_cnt_q == AW'(3)) begin
         start_rd_d = 1'b1;
      end

      // sof wins over everything else; a coincident pixel becomes address 0 of line 0
      if (sof) begin
         state_d     = ACTIVE;
         line_cnt_d  = '0;
         bank_d      = '0;
         pix_cnt_d   = '0;
         wr_addr_d   = '0;
         wren_d      = '0;
         start_rd_d  = 1'b0;
         err_short_d = 1'b0;
         err_long_d  = 1'b0;
         drop_d      = 1'b0;
         if (de_in) begin
            wren_d    = BANKS'(1);
            wr_data_d = pix_in;
            pix_cnt_d = AW'(1);
         end
      end
   end

   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign in0_wren  = wren_q[0];
   assign in1_wren  = wren_q[1];
   assign in2_wren  = wren_q[2];
   assign in3_wren  = wren_q[3];
   assign start_rd  = start_rd_q;
   assign line_cnt  = line_cnt_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;

endmodule

// File: tb/tb_line_buf_wr.sv
// Scoreboard bench for line_buf_wr: expected RAM writes are queued by the driver and popped by a monitor.
module tb_line_buf_wr;

   localparam int unsigned BD = 8;
   localparam int unsigned PW = BD * 3;
   localparam logic [10:0] W  = 11'd1920;
   localparam logic [10:0] H  = 11'd8;

   logic          clk = 1'b0;
   logic          RESET = 1'b1;
   logic          sof = 1'b0;
   logic          de_in = 1'b0;
   logic [PW-1:0] pix_in = '0;
   logic [10:0]   wr_addr;
   logic [PW-1:0] wr_data;
   logic          in0_wren, in1_wren, in2_wren, in3_wren;
   logic          start_rd;
   logic [10:0]   line_cnt;
   logic          err_short, err_long;

   int n_cmp = 0;
   int n_bad = 0;
   logic [36:0] sb[$];
   logic [3:0]  wren_v;

   line_buf_wr #(.bit_depth(BD), .image_width(W), .image_height(H)) dut (
      .clk(clk), .RESET(RESET), .sof(sof), .de_in(de_in), .pix_in(pix_in),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .in0_wren(in0_wren), .in1_wren(in1_wren), .in2_wren(in2_wren), .in3_wren(in3_wren),
      .start_rd(start_rd), .line_cnt(line_cnt), .err_short(err_short), .err_long(err_long)
   );

   always #5 clk = ~clk;

   assign wren_v = {in3_wren, in2_wren, in1_wren, in0_wren};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every RAM write must match the oldest expected write
   always @(negedge clk) begin
      if (wren_v != 4'b0) begin
         logic [1:0]  b;
         logic [36:0] e;
         logic [36:0] a;
         b = wren_v[3] ? 2'd3 : wren_v[2] ? 2'd2 : wren_v[1] ? 2'd1 : 2'd0;
         check("wren_onehot", 32'($onehot(wren_v)), 32'd1);
         a = {b, wr_addr, wr_data};
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got bank %0d addr %0d data %0h, required no write",
                     b, wr_addr, wr_data);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               n_bad++;
               $display("FAIL write: got bank %0d addr %0d data %0h, required bank %0d addr %0d data %0h",
                        a[36:35], a[34:24], a[23:0], e[36:35], e[34:24], e[23:0]);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_line(input int n, input int tag, input int bank,
                            input bit with_sof, input bit exp_wr, input bit keep_de);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sof    = with_sof && (i == 0);
         de_in  = 1'b1;
         pix_in = {8'(tag), 5'd0, 11'(i)};
         if (exp_wr && (i < int'(W))) sb.push_back({2'(bank), 11'(i), pix_in});
      end
      if (!keep_de) begin
         @(negedge clk);
         de_in = 1'b0;
         sof   = 1'b0;
      end
   endtask

   task automatic push_pad(input int from, input int bank);
      for (int a = from; a < int'(W); a++) sb.push_back({2'(bank), 11'(a), 24'd0});
   endtask

   initial begin
      bit ok;
      idle(3);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wren", 32'(wren_v), 32'd0);
      check("rst_start_rd", 32'(start_rd), 32'd0);
      check("rst_line_cnt", 32'(line_cnt), 32'd0);
      check("rst_err_short", 32'(err_short), 32'd0);
      check("rst_err_long", 32'(err_long), 32'd0);
      RESET = 1'b0;

      // de_in without sof is ignored in IDLE
      send_line(5, 1, 0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("idle_line_cnt", 32'(line_cnt), 32'd0);

      // sof with first pixel, then four full lines into banks 0..3
      send_line(int'(W), 2, 0, 1'b1, 1'b1, 1'b0);
      send_line(int'(W), 3, 1, 1'b0, 1'b1, 1'b0);
      send_line(int'(W), 4, 2, 1'b0, 1'b1, 1'b0);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (line_cnt == 11'd3) ok = 1'b1;
      end
      check("line_cnt_reaches_3", 32'(ok), 32'd1);
      check("start_rd_when_cnt3", 32'(start_rd), 32'd0);
      @(negedge clk);
      check("start_rd_cycle_after", 32'(start_rd), 32'd1);
      send_line(int'(W), 5, 3, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("four_lines_cnt", 32'(line_cnt), 32'd4);
      check("four_lines_err_long", 32'(err_long), 32'd0);
      check("four_lines_err_short", 32'(err_short), 32'd0);
      check("four_lines_start_rd", 32'(start_rd), 32'd1);

      // Long line: 1925 pixels, only 1920 written, bank wraps to 0
      send_line(1925, 6, 0, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("long_line_cnt", 32'(line_cnt), 32'd5);
      check("long_err_long", 32'(err_long), 32'd1);
      check("long_err_short", 32'(err_short), 32'd0);

      // Short line of 1000 pixels into bank 1
      send_line(1000, 7, 1, 1'b0, 1'b1, 1'b0);
`ifdef LBW_SHORT_PAD_EN
      push_pad(1000, 1);
`endif
      idle(int'(W) - 1000 + 8);
      check("short_line_cnt", 32'(line_cnt), 32'd6);
      check("short_err_short", 32'(err_short), 32'd1);

      // Next lines restart at address 0 of banks 2 and 3; frame completes at H lines
      send_line(int'(W), 8, 2, 1'b0, 1'b1, 1'b0);
      send_line(int'(W), 9, 3, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("frame_done_cnt", 32'(line_cnt), 32'(H));
      send_line(10, 10, 0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("done_cnt_saturated", 32'(line_cnt), 32'(H));
      check("done_start_rd_held", 32'(start_rd), 32'd1);

      // sof from DONE restarts the frame and clears flags
      send_line(int'(W), 11, 0, 1'b1, 1'b1, 1'b0);
      idle(3);
      check("sof_line_cnt", 32'(line_cnt), 32'd1);
      check("sof_err_long", 32'(err_long), 32'd0);
      check("sof_err_short", 32'(err_short), 32'd0);
      check("sof_start_rd", 32'(start_rd), 32'd0);

      // RESET at pixel 500 of line 2
      send_line(int'(W), 12, 1, 1'b0, 1'b1, 1'b0);
      send_line(500, 13, 2, 1'b0, 1'b1, 1'b1);
      check("pre_reset_line_cnt", 32'(line_cnt), 32'd2);
      @(negedge clk);
      RESET  = 1'b1;
      pix_in = {8'd13, 5'd0, 11'd500};
      @(negedge clk);
      check("mid_reset_wren", 32'(wren_v), 32'd0);
      check("mid_reset_start_rd", 32'(start_rd), 32'd0);
      check("mid_reset_line_cnt", 32'(line_cnt), 32'd0);
      check("mid_reset_wr_addr", 32'(wr_addr), 32'd0);
      RESET = 1'b0;
      de_in = 1'b0;

      // Restart after reset lands in bank 0 address 0
      send_line(5, 14, 0, 1'b1, 1'b1, 1'b0);
`ifdef LBW_SHORT_PAD_EN
      push_pad(5, 0);
`endif
      idle(int'(W) + 8);
      check("restart_line_cnt", 32'(line_cnt), 32'd1);
      check("restart_err_short", 32'(err_short), 32'd1);

      idle(5);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/line_buf_wr.md
LINE_BUF_WR -- requirements
Module: line_buf_wr

Interface
REQ-001 Parameter bit_depth, default 8, bits per colour channel; a pixel is bit_depth*3 bits.
REQ-002 Parameter image_width, default 11'd1920, active pixels per line.
REQ-003 Parameter image_height, default 11'd1080, lines per frame.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high (ports clk and RESET).
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- RESET  in  1  synchronous active-high reset.
- sof  in  1  one-cycle start-of-frame pulse.
- de_in  in  1  input pixel valid.
- pix_in  in  bit_depth*3  input pixel.
- wr_addr  out  11  line-RAM write address.
- wr_data  out  bit_depth*3  line-RAM write data.
- in0_wren, in1_wren, in2_wren, in3_wren  out  1 each  per-RAM write enables.
- start_rd  out  1  enables the downstream 3x3 convolution reader.
- line_cnt  out  11  completed lines in the current frame.
- err_short, err_long  out  1 each  sticky line-length error flags.

Function
REQ-006 FSM states SHALL be IDLE, ACTIVE, PAD and DONE; RESET forces IDLE.
REQ-007 IDLE -> ACTIVE on sof; de_in in IDLE SHALL be ignored.
REQ-008 sof in any state SHALL restart the frame: line_cnt=0, bank=0, wr_addr=0, start_rd=0, err flags cleared; state=ACTIVE.
REQ-009 Line n SHALL be written to RAM (n mod 4): bank 0->in0_wren ... bank 3->in3_wren; bank wraps 3->0.
REQ-010 Exactly one wren SHALL be high per accepted pixel, all wren low otherwise.
REQ-011 Write latency SHALL be 1 cycle: wr_addr/wr_data/wren register the pixel on the clock edge after de_in=1.
REQ-012 wr_addr SHALL start at 0 for each line and increment by 1 per accepted pixel.
REQ-013 A line SHALL end on the falling edge of de_in, or on reaching image_width pixels, whichever comes first.
REQ-014 Pixels beyond image_width within one de_in burst SHALL be dropped (no wren), and err_long SHALL be set.
REQ-015 On line end, line_cnt SHALL increment and bank SHALL advance, both in the cycle after the last write.
REQ-016 A line ending with fewer than image_width pixels SHALL set err_short; further handling is per REQ-023/024.
REQ-017 start_rd SHALL go high in the cycle after line_cnt becomes 3, and hold until sof or RESET.
- Rationale: the reader then consumes banks 0-2 while bank 3 is filled.
REQ-018 When line_cnt reaches image_height, the state SHALL be DONE: all further de_in ignored, start_rd held, until sof.
REQ-019 line_cnt SHALL saturate at image_height; it never wraps within a frame.
REQ-020 sof coincident with de_in SHALL take priority; that pixel is written as address 0 of line 0.

Reset
REQ-021 On RESET: state=IDLE, wr_addr=0, wr_data=0, all wren=0, start_rd=0, line_cnt=0, bank=0, err_short=0, err_long=0.
REQ-022 RESET mid-line SHALL abort the line immediately; no wren on the following cycle.

Configuration
REQ-023 With macro LBW_SHORT_PAD_EN defined, a short line SHALL enter PAD, which:
- writes wr_data=0 to the remaining addresses up to image_width-1 of the same bank, one per cycle;
- then performs the line end per REQ-015;
- drops de_in pixels arriving during PAD and sets err_long.
REQ-024 Without LBW_SHORT_PAD_EN, PAD SHALL not exist: a short line ends immediately per REQ-015, leaving the remaining addresses unwritten.

Verification
REQ-025 Scenario: RESET, sof, 4 lines of 1920 pixels (pix_in = address) -> banks 0,1,2,3 written addr 0..1919; start_rd rises 1 cycle after line_cnt=3; line_cnt=4.
REQ-026 Scenario: line of 1925 pixels -> 1920 writes, last wr_addr=1919, err_long=1, bank advances once.
REQ-027 Scenario: line of 1000 pixels.
- With LBW_SHORT_PAD_EN: zeros written at addr 1000..1919 over 920 cycles; err_short=1.
- Without LBW_SHORT_PAD_EN: next line starts at addr 0 of the next bank.
REQ-028 Scenario: 1080 full lines then extra de_in -> no wren after line 1080; line_cnt=1080; state DONE.
REQ-029 Scenario: RESET asserted at pixel 500 of line 2 -> next cycle all wren=0, start_rd=0, line_cnt=0; sof then restarts at bank 0.
REQ-030 Scenario: sof coincident with first de_in -> that pixel written at bank 0 addr 0 one cycle later.
